baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Parametrised, run-time programmable baud tick generator for the UART. Produces a single-cycle oversampling tick (default 16x) and a derived 1x bit tick, using an integer divisor plus an optional fractional accumulator to cut rate error. The divisor is reprogrammed through a load/ack handshake without glitching the tick stream. Feeds the UART rx and tx FSMs in place of the fixed-rate generator.

## Interface
- CLK_RATE, 50000000: input clock frequency in Hz; used only to compute reset divisor
- DEFAULT_BAUD, 9600: baud rate selected at reset
- OVERSAMPLE, 16: oversampling ticks per bit; power of two, at least 2
- DIV_W, 16: integer divisor width
- FRAC_W, 4: fractional divisor width; ignored when BAUD_FRAC_EN is undefined
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  run enable; low holds generator idle
- i_div_int  in  DIV_W  requested integer divisor, in clocks per oversample tick
- i_div_frac  in  FRAC_W  requested fractional divisor, in units of 1/2^FRAC_W clock
- i_div_load  in  1  one-cycle strobe; captures i_div_int/i_div_frac into shadow
- o_div_ack  out  1  one-cycle pulse when the shadow divisor becomes active
- o_tick  out  1  one-cycle oversample tick
- o_bit_tick  out  1  one-cycle tick coincident with every OVERSAMPLE-th o_tick
- o_phase  out  clog2(OVERSAMPLE)  oversample index within current bit, 0..OVERSAMPLE-1

## Operation
- Reset divisor: DEF_INT = CLK_RATE / (DEFAULT_BAUD*OVERSAMPLE). Default parameters give 325. DEF_FRAC = round of remaining fraction * 2^FRAC_W. Default parameters give 8.
- Reset state: all outputs 0, active divisor = DEF_INT/DEF_FRAC, no load pending, counters and accumulator cleared.
- Period counter counts down from P-1 to 0. o_tick is asserted on the cycle after it reaches 0 with i_en high.
- P = D normally. P = D+1 when the fractional accumulator (FRAC_W bits, adds F at each tick) carries out.
- Average tick period is D + F/2^FRAC_W clocks.
- Divisor clamp: an active integer divisor below 2 is treated as 2. Fraction is then still applied.
- Phase counter: increments on each o_tick and wraps OVERSAMPLE-1 -> 0. o_bit_tick = o_tick AND phase was OVERSAMPLE-1. o_phase shows the post-increment value.
- i_en low: period counter held at P-1; phase and accumulator cleared; o_tick and o_bit_tick held 0. Loads are still accepted.
- Load handshake:
  - i_div_load captures the inputs into the shadow register and sets pending.
  - A second load before the first is applied overwrites the shadow. Only one ack is produced.
  - With i_en high, the shadow is applied on the cycle the period counter reloads, i.e. at the tick boundary. The current period is never truncated.
  - With i_en low, the shadow is applied on the cycle after the load.
  - o_div_ack pulses on the apply cycle. Applying a new divisor clears the fractional accumulator.
  - Load and apply in the same cycle: the new capture wins and stays pending. The old shadow is applied and acked.
- Reset asserted mid-operation immediately returns to reset state. Any pending load is discarded and no ack is issued.

## Timing
- i_en rising at cycle 0: first o_tick at cycle D. Subsequent ticks every P cycles.
- o_div_ack to first period using the new divisor: 0 cycles. The reload on the ack cycle already uses it.
- All outputs are registered; no combinational path from inputs to outputs.
- o_tick never asserted on two consecutive cycles (P >= 2).

## Configuration
- BAUD_FRAC_EN defined: fractional accumulator present; i_div_frac and DEF_FRAC are used.
- BAUD_FRAC_EN undefined: accumulator removed and i_div_frac ignored. P = D always and DEF_FRAC is treated as 0.

## Structure
- Shared package uart_pkg: OVERSAMPLE default, DEF_INT/DEF_FRAC computation function, phase width constant.
- Sub-module baud_frac_acc: FRAC_W accumulator with add, clear and carry-out. Instantiated only under BAUD_FRAC_EN.

## Test plan
- Reset/default: with BAUD_FRAC_EN defined and default parameters, hold i_en=1 for 20000 clocks -> ticks spaced 325 or 326 clocks, alternating. 16 ticks take 5208 clocks ±1. o_bit_tick on every 16th tick.
- Without BAUD_FRAC_EN: same stimulus -> every spacing exactly 325 clocks.
- Load mid-period: running at D=325, pulse load with D=10, F=0 at 100 clocks after a tick -> ack 225 clocks later. Next tick 10 clocks after the ack, then every 10.
- Clamp and double load: load D=0, then D=1 one cycle later with i_en=0 -> single ack; after i_en rises, ticks every 2 clocks.
- Enable drop: deassert i_en at phase 7 -> o_phase=0 and no ticks. Reassert -> first tick exactly D clocks later, o_bit_tick after 16 ticks.
- Async reset mid-pending-load: assert i_rst_n=0 between load and apply -> no ack, divisor back to 325/8, outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud constants and reset divisor computation
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int PHASE_W = $clog2(OVERSAMPLE_DEF);
  // Fixed-point clocks per oversample tick; fraction rounded to nearest, rounding carry folds into the integer part
  function automatic longint def_div_fix(input longint clk_rate, input longint baud, input longint os, input int frac_w);
    longint den;
    den = baud * os;
    return ((clk_rate / den) << frac_w) + ((((clk_rate % den) << frac_w) + den / 2) / den);
  endfunction
endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional divisor accumulator with add, clear and carry-out
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_add,
  input  logic              i_clr,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, i_frac};
  assign o_carry = sum[FRAC_W];
  // Clear wins over add so a divisor change always restarts the fraction from zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) acc <= '0;
    else if (i_clr) acc <= '0;
    else if (i_add) acc <= sum[FRAC_W-1:0];
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable UART oversample and bit tick generator; define BAUD_FRAC_EN for the fractional divisor
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter longint CLK_RATE     = 50000000,
  parameter longint DEFAULT_BAUD = 9600,
  parameter int     OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int     DIV_W        = 16,
  parameter int     FRAC_W       = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [DIV_W-1:0]              i_div_int,
  input  logic [FRAC_W-1:0]             i_div_frac,
  input  logic                          i_div_load,
  output logic                          o_div_ack,
  output logic                          o_tick,
  output logic                          o_bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_phase
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam longint DEF_FIX = def_div_fix(CLK_RATE, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DEF_FIX >> FRAC_W);
  logic [DIV_W-1:0] act_int, shd_int, nxt_int, eff_int, cnt;
  logic pending, reload, apply, carry;
  assign reload = i_en && cnt == '0;
  assign apply = pending && (i_en ? reload : !i_div_load);
  assign nxt_int = apply ? shd_int : act_int;
  assign eff_int = nxt_int < DIV_W'(2) ? DIV_W'(2) : nxt_int;
`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FIX);
  logic [FRAC_W-1:0] act_frac, shd_frac;
  logic acc_carry;
  baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_add   (reload),
    .i_clr   (!i_en || apply),
    .i_frac  (act_frac),
    .o_carry (acc_carry)
  );
  assign carry = acc_carry && !apply;
`else
  logic unused_frac;
  assign unused_frac = ^i_div_frac;
  assign carry = 1'b0;
`endif
  // Shadow capture and apply handshake; a fresh load in the apply cycle stays pending
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pending <= 1'b0;
      shd_int <= DEF_INT;
      act_int <= DEF_INT;
      o_div_ack <= 1'b0;
`ifdef BAUD_FRAC_EN
      shd_frac <= DEF_FRAC;
      act_frac <= DEF_FRAC;
`endif
    end else begin
      o_div_ack <= apply;
      pending <= i_div_load || (pending && !apply);
      if (apply) act_int <= shd_int;
      if (i_div_load) shd_int <= i_div_int;
`ifdef BAUD_FRAC_EN
      if (apply) act_frac <= shd_frac;
      if (i_div_load) shd_frac <= i_div_frac;
`endif
    end
  // Period countdown, registered ticks and oversample phase; idle holds the counter at P-1
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      o_tick <= 1'b0;
      o_bit_tick <= 1'b0;
      o_phase <= '0;
    end else if (!i_en) begin
      cnt <= eff_int - DIV_W'(1);
      o_tick <= 1'b0;
      o_bit_tick <= 1'b0;
      o_phase <= '0;
    end else begin
      cnt <= reload ? eff_int - DIV_W'(1) + DIV_W'(carry) : cnt - DIV_W'(1);
      o_tick <= reload;
      o_bit_tick <= reload && o_phase == PW'(OVERSAMPLE - 1);
      if (reload) o_phase <= o_phase + PW'(1);
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scoreboard bench for baud_tick_gen, follows BAUD_FRAC_EN for the expected fraction
module tb_baud_tick_gen;
  localparam int OS = 16;
  localparam int D0 = 325;
`ifdef BAUD_FRAC_EN
  localparam int F0 = 8;
`else
  localparam int F0 = 0;
`endif
  typedef struct {
    int c;
    int ph;
    bit bt;
  } tick_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0] div_frac = '0;
  logic ack, tick, bit_tick;
  logic [3:0] phase;
  int cyc = 0, checks = 0, failures = 0;
  tick_t q_tick[$];
  int q_ack[$];
  int m_t, m_last, m_d, m_f, m_acc, m_ph, l_cyc;

  baud_tick_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_div_int  (div_int),
    .i_div_frac (div_frac),
    .i_div_load (load),
    .o_div_ack  (ack),
    .o_tick     (tick),
    .o_bit_tick (bit_tick),
    .o_phase    (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tick) begin
      if (q_tick.size() == 0) chk("tick_unexpected", 1, 0);
      else begin
        tick_t e;
        e = q_tick.pop_front();
        chk("tick_cycle", cyc, e.c);
        chk("tick_phase", phase, e.ph);
        chk("bit_tick", bit_tick, e.bt);
      end
    end else if (bit_tick) chk("bit_tick_without_tick", 1, 0);
    if (ack) begin
      if (q_ack.size() == 0) chk("ack_unexpected", 1, 0);
      else chk("ack_cycle", cyc, q_ack.pop_front());
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_tick();
    tick_t e;
    logic [4:0] s;
    e.c = m_t;
    e.ph = (m_ph + 1) % OS;
    e.bt = (m_ph == OS - 1);
    q_tick.push_back(e);
    m_ph = e.ph;
    m_last = m_t;
    s = 5'(m_acc + m_f);
    m_acc = int'(s[3:0]);
    m_t += m_d + int'(s[4]);
  endtask

  task automatic exp_tick_apply(input int d, input int f);
    tick_t e;
    e.c = m_t;
    e.ph = (m_ph + 1) % OS;
    e.bt = (m_ph == OS - 1);
    q_tick.push_back(e);
    q_ack.push_back(m_t);
    m_ph = e.ph;
    m_last = m_t;
    m_t += d;
    m_d = d;
    m_f = f;
    m_acc = 0;
  endtask

  task automatic start_en();
    en = 1'b1;
    m_t = cyc + m_d;
    m_acc = 0;
    m_ph = 0;
  endtask

  task automatic drop_en();
    wait_cyc(m_last + 1);
    en = 1'b0;
  endtask

  task automatic pulse_load(input int d, input int f);
    div_int = 16'(d);
    div_frac = 4'(f);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_bit_tick", bit_tick, 0);
    chk("rst_ack", ack, 0);
    chk("rst_phase", phase, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_d = D0;
    m_f = F0;
    // free run at the reset divisor
    start_en();
    repeat (20) exp_tick();
    // reload mid-period: current period completes, ack coincides with the boundary tick
    wait_cyc(m_last + 100);
    pulse_load(10, 0);
    exp_tick_apply(10, 0);
    repeat (6) exp_tick();
    // enable drop at phase 7, then restart
    while (m_ph != 7) exp_tick();
    drop_en();
    wait_cyc(m_last + 3);
    chk("idle_phase", phase, 0);
    chk("idle_tick", tick, 0);
    wait_cyc(m_last + 30);
    start_en();
    repeat (17) exp_tick();
    // async reset between load and apply: no ack, reset divisor restored
    wait_cyc(m_last + 2);
    pulse_load(50, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_bit_tick", bit_tick, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_phase", phase, 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_rst_ack", ack, 0);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    m_d = D0;
    m_f = F0;
    start_en();
    repeat (4) exp_tick();
    // clamp and double load while idle: a single ack, then period 2
    drop_en();
    wait_cyc(m_last + 5);
    l_cyc = cyc;
    pulse_load(0, 0);
    pulse_load(1, 0);
    q_ack.push_back(l_cyc + 3);
    m_d = 2;
    m_f = 0;
    wait_cyc(l_cyc + 6);
    start_en();
    repeat (8) exp_tick();
    drop_en();
    wait_cyc(m_last + 20);
    chk("tick_queue_empty", q_tick.size(), 0);
    chk("ack_queue_empty", q_ack.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
